// File: rtl/sc_load_store_unit_if.sv
// Request/response and data-memory bus between the datapath, the load/store unit and memory.
// The slave modport is the load/store unit's view; master is the surrounding environment.
interface sc_load_store_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_error;
   logic              mem_enable;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  resp_ready, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_error,
      output mem_enable, mem_read, mem_write, mem_address, mem_write_data
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output resp_ready, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_error,
      input  mem_enable, mem_read, mem_write, mem_address, mem_write_data
   );
endinterface

// File: rtl/sc_load_store_unit.sv
// Load/store unit: one request at a time, big-endian lanes, sub-word stores via read-modify-write.
// Memory has a combinational word read and a clocked word write.
module sc_load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic                clk,
   input logic                reset_n,
   sc_load_store_unit_if.slave bus
);
   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StRead  = 3'd1;
   localparam logic [2:0] StWrite = 3'd2;
   localparam logic [2:0] StErr   = 3'd3;
   localparam logic [2:0] StResp  = 3'd4;

   localparam logic [1:0] SizeByte = 2'b00;
   localparam logic [1:0] SizeHalf = 2'b01;
   localparam logic [1:0] SizeWord = 2'b10;

   logic [2:0]        state_q, state_d;
   logic              write_q;
   logic [1:0]        size_q;
   logic              unsigned_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] old_word_q;
   logic [DATA_W-1:0] rdata_q;
   logic              error_q;

   logic              accept;
   logic              bad_req;
   logic [7:0]        lane_byte;
   logic [15:0]       lane_half;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] merged;

   assign accept  = (state_q == StIdle) && bus.req_valid;
   assign bad_req = (bus.req_size == 2'b11) ||
                    ((bus.req_size == SizeHalf) && bus.req_addr[0]) ||
                    ((bus.req_size == SizeWord) && (bus.req_addr[1:0] != 2'b00));

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               if (bad_req)                                          state_d = StErr;
               else if (bus.req_write && (bus.req_size == SizeWord)) state_d = StWrite;
               else                                                  state_d = StRead;
            end
         end
         StRead:  state_d = write_q ? StWrite : StResp;
         StWrite: state_d = StResp;
         StErr:   state_d = StResp;
         StResp:  if (bus.resp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Load lane select: offset 0 is the most significant byte/half.
   always_comb begin
      lane_byte = 8'h00;
      unique case (addr_q[1:0])
         2'd0: lane_byte = bus.mem_read_data[31:24];
         2'd1: lane_byte = bus.mem_read_data[23:16];
         2'd2: lane_byte = bus.mem_read_data[15:8];
         2'd3: lane_byte = bus.mem_read_data[7:0];
         default: lane_byte = 8'h00;
      endcase
      lane_half = addr_q[1] ? bus.mem_read_data[15:0] : bus.mem_read_data[31:16];
      case (size_q)
         SizeByte: load_data = unsigned_q ? {24'h000000, lane_byte}
                                          : {{24{lane_byte[7]}}, lane_byte};
         SizeHalf: load_data = unsigned_q ? {16'h0000, lane_half}
                                          : {{16{lane_half[15]}}, lane_half};
         default:  load_data = bus.mem_read_data;
      endcase
   end

   always_comb begin
      merged = old_word_q;
      case (size_q)
         SizeByte: begin
            unique case (addr_q[1:0])
               2'd0: merged[31:24] = wdata_q[7:0];
               2'd1: merged[23:16] = wdata_q[7:0];
               2'd2: merged[15:8]  = wdata_q[7:0];
               2'd3: merged[7:0]   = wdata_q[7:0];
               default: merged = old_word_q;
            endcase
         end
         SizeHalf: begin
            if (addr_q[1]) merged[15:0]  = wdata_q[15:0];
            else           merged[31:16] = wdata_q[15:0];
         end
         default: merged = wdata_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         write_q    <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         old_word_q <= '0;
         rdata_q    <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  write_q    <= bus.req_write;
                  size_q     <= bus.req_size;
                  unsigned_q <= bus.req_unsigned;
                  addr_q     <= bus.req_addr;
                  wdata_q    <= bus.req_wdata;
                  rdata_q    <= '0;
                  error_q    <= 1'b0;
               end
            end
            StRead: begin
               old_word_q <= bus.mem_read_data;
               if (!write_q) rdata_q <= load_data;
            end
            StErr: error_q <= 1'b1;
            StResp: begin
               if (bus.resp_ready) begin
                  rdata_q <= '0;
                  error_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Memory strobes decode straight from state so an async reset drops them at once.
   assign bus.req_ready      = (state_q == StIdle);
   assign bus.resp_valid     = (state_q == StResp);
   assign bus.resp_rdata     = rdata_q;
   assign bus.resp_error     = error_q;
   assign bus.mem_read       = (state_q == StRead);
   assign bus.mem_write      = (state_q == StWrite);
   assign bus.mem_enable     = (state_q == StWrite);
   assign bus.mem_address    = ((state_q == StRead) || (state_q == StWrite)) ?
                               {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign bus.mem_write_data = (state_q == StWrite) ? merged : '0;
endmodule

// File: tb/tb_sc_load_store_unit.sv
// Directed bench for sc_load_store_unit with a small word memory model.
module tb_sc_load_store_unit;
   logic clk = 1'b0;
   logic reset_n = 1'b0;

   sc_load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   sc_load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:15];
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          both_cnt = 0;
   logic [31:0] last_wdata = 32'h0;

   assign bus.mem_read_data = mem[bus.mem_address[5:2]];

   always @(posedge clk) begin
      if (bus.mem_read) rd_cnt <= rd_cnt + 1;
      if (bus.mem_read && bus.mem_write) both_cnt <= both_cnt + 1;
      if (bus.mem_enable && bus.mem_write) begin
         wr_cnt                     <= wr_cnt + 1;
         last_wdata                 <= bus.mem_write_data;
         mem[bus.mem_address[5:2]] <= bus.mem_write_data;
      end
   end

   int checks = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h required %h", tag, obs, exp);
   endtask

   task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic err,
                         output int nrd, output int nwr);
      int rd0, wr0, n;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_write    = wr;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("accept_timeout", {31'h0, bus.req_ready}, 32'h1);
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (bus.resp_valid !== 1'b1 && lat < 20);
      if (lat >= 20) check("resp_timeout", {31'h0, bus.resp_valid}, 32'h1);
      rd  = bus.resp_rdata;
      err = bus.resp_error;
      nrd = rd_cnt - rd0;
      nwr = wr_cnt - wr0;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
   endtask

   int          lat, nrd, nwr, wr_snap;
   logic [31:0] rdata;
   logic        err;

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      bus.resp_ready   = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
      check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      check("rst_resp_rdata", bus.resp_rdata, 32'h0);
      check("rst_resp_error", {31'h0, bus.resp_error}, 32'h0);
      check("rst_mem_strobes", {29'h0, bus.mem_enable, bus.mem_read, bus.mem_write}, 32'h0);
      check("rst_mem_address", bus.mem_address, 32'h0);
      check("rst_mem_wdata", bus.mem_write_data, 32'h0);
      reset_n = 1'b1;

      // Word store then word load
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, lat, rdata, err, nrd, nwr);
      check("sw_latency", lat, 2);
      check("sw_no_read", nrd, 0);
      check("sw_one_write", nwr, 1);
      check("sw_mem4", mem[4], 32'h12345678);
      check("sw_rdata", rdata, 32'h0);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdata, err, nrd, nwr);
      check("lw_latency", lat, 2);
      check("lw_rdata", rdata, 32'h12345678);
      check("lw_no_write", nwr, 0);

      // Byte store read-modify-write
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hAABBCCDD, lat, rdata, err, nrd, nwr);
      do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFF11, lat, rdata, err, nrd, nwr);
      check("sb_latency", lat, 3);
      check("sb_one_read", nrd, 1);
      check("sb_one_write", nwr, 1);
      check("sb_wdata", last_wdata, 32'hAABB11DD);
      check("sb_mem4", mem[4], 32'hAABB11DD);
      do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF, lat, rdata, err, nrd, nwr);
      check("sh_mem4", mem[4], 32'hBEEF11DD);

      // Load extraction and extension
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, lat, rdata, err, nrd, nwr);
      do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, rdata, err, nrd, nwr);
      check("lb_0x10", rdata, 32'hFFFFFF80);
      do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, lat, rdata, err, nrd, nwr);
      check("lbu_0x10", rdata, 32'h00000080);
      do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rdata, err, nrd, nwr);
      check("lh_0x12", rdata, 32'h00007F01);
      do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, rdata, err, nrd, nwr);
      check("lh_0x10", rdata, 32'hFFFF80FF);
      do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, rdata, err, nrd, nwr);
      check("lhu_0x10", rdata, 32'h000080FF);
      do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rdata, err, nrd, nwr);
      check("lb_0x11", rdata, 32'hFFFFFFFF);
      do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rdata, err, nrd, nwr);
      check("lb_0x13", rdata, 32'h00000001);

      // Misaligned and illegal-size requests
      do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, rdata, err, nrd, nwr);
      check("lh_mis_err", {31'h0, err}, 32'h1);
      check("lh_mis_rdata", rdata, 32'h0);
      check("lh_mis_latency", lat, 2);
      check("lh_mis_noacc", nrd + nwr, 0);
      do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, lat, rdata, err, nrd, nwr);
      check("lw_mis_err", {31'h0, err}, 32'h1);
      check("lw_mis_rdata", rdata, 32'h0);
      check("lw_mis_noacc", nrd + nwr, 0);
      do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, lat, rdata, err, nrd, nwr);
      check("size11_err", {31'h0, err}, 32'h1);
      check("size11_noacc", nrd + nwr, 0);
      check("size11_mem4", mem[4], 32'h80FF7F01);

      // Response held for 5 cycles while a new request waits
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_size  = 2'b10;
      bus.req_addr  = 32'h10;
      @(posedge clk);
      #1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h20;
      bus.req_wdata = 32'hDEADBEEF;
      wr_snap = wr_cnt;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("hold_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
         check("hold_rdata", bus.resp_rdata, 32'h80FF7F01);
         check("hold_req_ready", {31'h0, bus.req_ready}, 32'h0);
         @(negedge clk);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b0;
      check("hold_after_idle", {31'h0, bus.req_ready}, 32'h1);
      @(negedge clk);
      check("hold_no_write", wr_cnt - wr_snap, 0);
      check("hold_still_idle", {31'h0, bus.req_ready}, 32'h1);

      // Reset during the READ of a byte store
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEBABE, lat, rdata, err, nrd, nwr);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_size  = 2'b00;
      bus.req_addr  = 32'h11;
      bus.req_wdata = 32'h00000055;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      wr_snap = wr_cnt;
      check("rmw_in_read", {31'h0, bus.mem_read}, 32'h1);
      #1 reset_n = 1'b0;
      #1;
      check("arst_strobes", {29'h0, bus.mem_enable, bus.mem_read, bus.mem_write}, 32'h0);
      check("arst_req_ready", {31'h0, bus.req_ready}, 32'h1);
      check("arst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      check("arst_mem_address", bus.mem_address, 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("arst_no_write", wr_cnt - wr_snap, 0);
      check("arst_mem4", mem[4], 32'hCAFEBABE);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdata, err, nrd, nwr);
      check("post_rst_lw", rdata, 32'hCAFEBABE);
      check("post_rst_latency", lat, 2);
      check("never_rd_and_wr", both_cnt, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/sc_load_store_unit.md
Name: sc_load_store_unit

Overview:
- Initiator-side memory access controller between the MIPS datapath and the word-addressed data memory.
- Accepts one load/store request at a time through a valid/ready handshake and checks alignment.
- Drives the memory's enable/read/write/address/data strobes; the memory has a combinational word read and a clocked word write.
- Sub-word stores become read-modify-write sequences. Load data is byte/halfword-extracted, then sign- or zero-extended. Results return on a held response channel.

Parameters:
- ADDR_W, 32, width of request and memory address.
- DATA_W, 32, word width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_error  out  1  misaligned access or illegal size
- mem_enable  out  1  memory write enable qualifier
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  32  word-aligned address {addr[31:2],2'b00}
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  combinational read word

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_error=0; all mem_* outputs 0; internal registers cleared.
- Reset asserted mid-operation aborts immediately. An in-flight RMW write that has not reached its WRITE edge is never issued.
- Accept: req_valid && req_ready on a rising edge. The unit latches write, size, unsigned, addr, wdata.
- States:
  - IDLE -> ERR if misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11.
  - IDLE -> READ for loads and for byte/half stores.
  - IDLE -> WRITE for word stores.
  - READ: mem_read=1, mem_address valid. Capture mem_read_data into old_word. Next state is RESP for a load, WRITE for a sub-word store.
  - WRITE: mem_enable=1, mem_write=1, mem_write_data=merged word. Next state RESP.
  - ERR: no memory access. Next state RESP with resp_error=1.
  - RESP: resp_valid=1, outputs held stable until resp_ready. On resp_ready, go to IDLE.
- mem_read and mem_write are never asserted in the same cycle, and neither is asserted in IDLE, ERR or RESP.
- Latency, accept edge to resp_valid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 2 cycles
- A new request is accepted no earlier than the cycle after the response handshake (no overlap).
- Byte order is big-endian:
  - byte offset 0 = bits[31:24], offset 3 = bits[7:0].
  - halfword offset 0 = bits[31:16], offset 2 = bits[15:0].
- Store merge: replace only the addressed lane of old_word with the low byte/half of wdata. Other lanes are preserved bit-exact.
- Load extract: select the lane, then extend to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- resp_rdata is 0 on stores and on errors.
- req_valid asserted while req_ready=0 is ignored. The requester must hold it.

Test Plan:
- Word store 0x12345678 @0x10, then word load @0x10 -> memory word 4 = 0x12345678; load resp_rdata=0x12345678; each resp_valid 2 cycles after accept; no mem_read during the store.
- Preload word 4 = 0xAABBCCDD; SB 0x11 @0x12 -> one READ cycle then one WRITE with mem_write_data=0xAABB11DD; resp 3 cycles after accept.
- Word 4 = 0x80FF7F01:
  - LB @0x10 -> 0xFFFFFF80.
  - LBU @0x10 -> 0x00000080.
  - LH @0x12 -> 0x00007F01.
  - LH @0x10 -> 0xFFFF80FF.
- LH @0x11 and LW @0x12 -> resp_error=1, resp_rdata=0, mem_read/mem_write never asserted.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0; accept occurs only after the handshake.
- Assert reset_n=0 during READ of an SB -> outputs at reset values asynchronously, mem_write never pulses, target word unchanged; the next request completes normally.
